// File: rtl/palette_pkg.sv
// Shared types for the palette Avalon writer: the address/colour types, the queued command
// record, the writer FSM states and the Avalon constants.
// Latency: none (declarations only). Backpressure: not applicable.
package palette_pkg;

    typedef logic [4:0]  pal_addr_t;   // {palette[2:0], color_index[1:0]}
    typedef logic [23:0] rgb_t;        // R in [23:16], G in [15:8], B in [7:0]

    typedef struct packed {
        pal_addr_t addr;
        rgb_t      rgb;
        logic      verify;             // read back and compare after the write
    } pal_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT_RD,
        ST_CHECK
    } pal_wr_state_t;

    localparam int         PAL_WORDS  = 32;
    localparam logic [3:0] AVL_BE_ALL = 4'hF;

    // The palette slave only stores 24 bits; the top byte is driven as zero.
    function automatic logic [31:0] pal_wdata(input rgb_t rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/palette_cmd_fifo.sv
// Command queue for palette writes: synchronous FIFO of pal_cmd_t with head-of-queue read.
// Latency: a pushed entry is visible at rd_data the cycle after the push edge.
// Backpressure: full is count based; push while full and pop while empty are ignored.
// Ports: clk/rst (sync, active-high), push/wr_data, pop/rd_data, full, empty, count.
module palette_cmd_fifo
    import palette_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pal_cmd_t                 wr_data,
    input  logic                     pop,
    output pal_cmd_t                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    pal_cmd_t      mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/palette_avl_writer.sv
// Avalon-MM initiator that writes queued palette entries and optionally reads them back to verify.
// Latency: entry accepted at edge k has AVL_WRITE high in the cycle after edge k+1; writes stream one per cycle.
// Backpressure: in_ready = !full (registered count, no same-cycle refill), forced low while RESET is high.
// Ports: CLK/RESET; in_valid/in_ready/in_addr/in_rgb/verify_en entry stream; clr_err;
//        AVL_* single-cycle write/read master (no waitrequest); busy, mismatch, mismatch_addr status.
module palette_avl_writer
    import palette_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_addr,
    input  logic [23:0] in_rgb,
    input  logic        verify_en,
    input  logic        clr_err,
    output logic        AVL_CS,
    output logic        AVL_WRITE,
    output logic        AVL_READ,
    output logic [4:0]  AVL_ADDR,
    output logic [31:0] AVL_WRITEDATA,
    output logic [3:0]  AVL_BYTE_EN,
    input  logic [31:0] AVL_READDATA,
    output logic        busy,
    output logic        mismatch,
    output logic [4:0]  mismatch_addr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    // ---------------- command queue ----------------
    pal_cmd_t        fifo_wr_data;
    pal_cmd_t        fifo_head;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign in_ready     = !fifo_full && !RESET;
    assign fifo_push    = in_valid && in_ready;
    assign fifo_wr_data = '{addr: in_addr, rgb: in_rgb, verify: verify_en};

    palette_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ---------------- FSM and registered Avalon outputs ----------------
    pal_wr_state_t   state_q, state_d;
    pal_cmd_t        cmd_q, cmd_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
    logic            rd_fail;

    logic            avl_cs_q, avl_cs_d;
    logic            avl_write_q, avl_write_d;
    logic            avl_read_q, avl_read_d;
    logic [4:0]      avl_addr_q, avl_addr_d;
    logic [31:0]     avl_wdata_q, avl_wdata_d;
    logic [3:0]      avl_be_q, avl_be_d;
    logic            mismatch_q, mismatch_d;
    logic [4:0]      mismatch_addr_q, mismatch_addr_d;

    // Only the 24 RGB bits of read data take part in the compare.
    logic            unused_rd_hi;
    assign unused_rd_hi = ^AVL_READDATA[31:24];

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        lat_cnt_d = lat_cnt_q;
        fifo_pop  = 1'b0;
        rd_fail   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cmd_q.verify) begin
                    state_d = ST_READ;
                end else if (!fifo_empty) begin
                    // Back-to-back: the next write goes out in the very next cycle.
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    state_d  = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // READ_LATENCY-1 cycles of WAIT_RD put CHECK on the cycle the data arrives.
                lat_cnt_d = LW'(READ_LATENCY - 1);
                if (READ_LATENCY == 1) state_d = ST_CHECK;
                else                   state_d = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                lat_cnt_d = lat_cnt_q - LW'(1);
                if (lat_cnt_d == '0) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                rd_fail = (AVL_READDATA[23:0] != cmd_q.rgb);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state, so strobes line up with the state they name.
        avl_write_d = (state_d == ST_WRITE);
        avl_read_d  = (state_d == ST_READ);
        avl_cs_d    = avl_write_d || avl_read_d;
        avl_be_d    = avl_cs_d ? AVL_BE_ALL : 4'h0;
        avl_addr_d  = avl_cs_d    ? cmd_d.addr            : avl_addr_q;
        avl_wdata_d = avl_write_d ? pal_wdata(cmd_d.rgb)  : avl_wdata_q;

        // A failure in the same cycle as clr_err wins.
        mismatch_d      = mismatch_q && !clr_err;
        mismatch_addr_d = mismatch_addr_q;
        if (rd_fail) begin
            mismatch_d      = 1'b1;
            mismatch_addr_d = cmd_q.addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= ST_IDLE;
            cmd_q           <= '0;
            lat_cnt_q       <= '0;
            avl_cs_q        <= 1'b0;
            avl_write_q     <= 1'b0;
            avl_read_q      <= 1'b0;
            avl_addr_q      <= '0;
            avl_wdata_q     <= '0;
            avl_be_q        <= '0;
            mismatch_q      <= 1'b0;
            mismatch_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            lat_cnt_q       <= lat_cnt_d;
            avl_cs_q        <= avl_cs_d;
            avl_write_q     <= avl_write_d;
            avl_read_q      <= avl_read_d;
            avl_addr_q      <= avl_addr_d;
            avl_wdata_q     <= avl_wdata_d;
            avl_be_q        <= avl_be_d;
            mismatch_q      <= mismatch_d;
            mismatch_addr_q <= mismatch_addr_d;
        end
    end

    assign AVL_CS        = avl_cs_q;
    assign AVL_WRITE     = avl_write_q;
    assign AVL_READ      = avl_read_q;
    assign AVL_ADDR      = avl_addr_q;
    assign AVL_WRITEDATA = avl_wdata_q;
    assign AVL_BYTE_EN   = avl_be_q;
    assign mismatch      = mismatch_q;
    assign mismatch_addr = mismatch_addr_q;

    assign busy = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule
